// File: rtl/msk_mixcolumns_pipe.sv
// Share-wise masked AES MixColumns with a PIPE-deep valid/ready pipeline and 128-bit state beat tracking.
// Define MSK_INVMC_EN to add the in_inv port and InvMixColumns datapath.
module msk_mixcolumns_pipe #(
  parameter int d    = 2,
  parameter int NCOL = 1,
  parameter int PIPE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*d*NCOL-1:0] in_sh,
  input  logic                 in_bypass,
`ifdef MSK_INVMC_EN
  input  logic                 in_inv,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*d*NCOL-1:0] out_sh,
  output logic                 out_last
);

  localparam int         W        = 32 * d * NCOL;
  localparam logic [1:0] LAST_CNT = 2'(4 / NCOL - 1);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      a[b]  = col[8*b +: 8];
      x2[b] = xtime(a[b]);
    end
    res = '0;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = x2[b] ^ x2[(b+1)%4] ^ a[(b+1)%4] ^ a[(b+2)%4] ^ a[(b+3)%4];
    end
    return res;
  endfunction

`ifdef MSK_INVMC_EN
  // 0e/0b/0d/09 assembled from the x2/x4/x8 xtime chain of each byte
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      a[b]  = col[8*b +: 8];
      x2[b] = xtime(a[b]);
      x4[b] = xtime(x2[b]);
      x8[b] = xtime(x4[b]);
    end
    res = '0;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = (x8[b] ^ x4[b] ^ x2[b])
                    ^ (x8[(b+1)%4] ^ x2[(b+1)%4] ^ a[(b+1)%4])
                    ^ (x8[(b+2)%4] ^ x4[(b+2)%4] ^ a[(b+2)%4])
                    ^ (x8[(b+3)%4] ^ a[(b+3)%4]);
    end
    return res;
  endfunction
`endif

  logic [W-1:0]    mix_data;
  logic [31:0]     col;
  logic [W-1:0]    st_data [PIPE];
  logic [PIPE-1:0] st_valid;
  logic [PIPE-1:0] st_last;
  logic [PIPE-1:0] ld;
  logic [1:0]      beat_cnt;
  logic            accept;
  logic            beat_last;

  // Each share is gathered from the interleaved layout, transformed alone, and scattered back
  always_comb begin
    mix_data = in_sh;
    col      = '0;
    if (!in_bypass) begin
      for (int c = 0; c < NCOL; c++) begin
        for (int s = 0; s < d; s++) begin
          for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
              col[8*b+i] = in_sh[(4*c+b)*8*d + i*d + s];
            end
          end
`ifdef MSK_INVMC_EN
          col = in_inv ? mix_inv(col) : mix_fwd(col);
`else
          col = mix_fwd(col);
`endif
          for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
              mix_data[(4*c+b)*8*d + i*d + s] = col[8*b+i];
            end
          end
        end
      end
    end
  end

  // A stage may load if the output drains or any stage at or after it has a hole
  always_comb begin
    ld = '0;
    for (int k = 0; k < PIPE; k++) begin
      ld[k] = out_ready;
      for (int j = k; j < PIPE; j++) begin
        if (!st_valid[j]) ld[k] = 1'b1;
      end
    end
  end

  assign in_ready  = ld[0];
  assign accept    = in_valid && ld[0];
  assign beat_last = (beat_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE; k++) st_data[k] <= '0;
      st_valid <= '0;
      st_last  <= '0;
      beat_cnt <= '0;
    end else begin
      if (accept) beat_cnt <= beat_last ? 2'd0 : beat_cnt + 2'd1;
      if (ld[0]) begin
        st_valid[0] <= in_valid;
        if (in_valid) begin
          st_data[0] <= mix_data;
          st_last[0] <= beat_last;
        end
      end
      for (int k = 1; k < PIPE; k++) begin
        if (ld[k]) begin
          st_valid[k] <= st_valid[k-1];
          if (st_valid[k-1]) begin
            st_data[k] <= st_data[k-1];
            st_last[k] <= st_last[k-1];
          end
        end
      end
    end
  end

  assign out_valid = st_valid[PIPE-1];
  assign out_last  = st_last[PIPE-1];
  assign out_sh    = st_data[PIPE-1];

endmodule

// File: tb/tb_msk_mixcolumns_pipe.sv
// Randomized bench for msk_mixcolumns_pipe: GF(2^8) matrix reference model with a scoreboard of expected beats.
module tb_msk_mixcolumns_pipe;

  localparam int D    = 2;
  localparam int NCOL = 1;
  localparam int PIPE = 2;
  localparam int W    = 32 * D * NCOL;
  localparam int BPS  = 4 / NCOL;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sh;
  logic         in_bypass;
`ifdef MSK_INVMC_EN
  logic         in_inv;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sh;
  logic         out_last;

  always #5 clk = ~clk;

  msk_mixcolumns_pipe #(.d(D), .NCOL(NCOL), .PIPE(PIPE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sh     (in_sh),
    .in_bypass (in_bypass),
`ifdef MSK_INVMC_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sh    (out_sh),
    .out_last  (out_last)
  );

  typedef struct {
    logic [W-1:0] sh;
    logic         last;
    logic         kn;
    logic [31:0]  plain;
  } exp_t;

  exp_t         sb [$];
  int           checks = 0;
  int           passes = 0;
  int           beat_n = 0;
  logic         obs_ready;
  logic         obs_valid;
  logic [W-1:0] obs_sh;

  function automatic logic [31:0] col4(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product: row r uses coefficient cf[(k-r) mod 4] on byte k
  function automatic logic [31:0] ref_mix(input logic [31:0] c, input logic inv);
    logic [7:0]  cf [4];
    logic [7:0]  acc;
    logic [31:0] res;
    if (inv) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[(k - r + 4) % 4], c[8*k +: 8]);
      res[8*r +: 8] = acc;
    end
    return res;
  endfunction

  function automatic logic [W-1:0] pack_sh(input logic [D-1:0][31:0] s);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < D; j++)
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 8; i++) v[b*8*D + i*D + j] = s[j][8*b+i];
    return v;
  endfunction

  function automatic logic [31:0] unmask(input logic [W-1:0] v);
    logic [31:0] p;
    p = '0;
    for (int j = 0; j < D; j++)
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 8; i++) p[8*b+i] = p[8*b+i] ^ v[b*8*D + i*D + j];
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check any drained beat, record any accepted beat
  task automatic applyStimulus(input logic v, input logic [31:0] plain, input logic byp,
                               input logic inv, input logic ordy,
                               input logic kn, input logic [31:0] known);
    logic [D-1:0][31:0] s;
    logic [D-1:0][31:0] e;
    logic [31:0]        rest;
    logic               use_inv;
    exp_t               ex;
    exp_t               got;
    rest = plain;
    for (int j = 0; j < D - 1; j++) begin
      s[j] = $urandom;
      rest = rest ^ s[j];
    end
    s[D-1] = rest;
    use_inv = 1'b0;
`ifdef MSK_INVMC_EN
    use_inv = inv;
`endif
    for (int j = 0; j < D; j++) e[j] = byp ? s[j] : ref_mix(s[j], use_inv);
    @(negedge clk);
    in_valid  = v;
    in_sh     = pack_sh(s);
    in_bypass = byp;
`ifdef MSK_INVMC_EN
    in_inv    = inv;
`endif
    out_ready = ordy;
    #1;
    obs_ready = in_ready;
    obs_valid = out_valid;
    obs_sh    = out_sh;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", W'(out_valid), W'(1'b0));
      end else begin
        got = sb.pop_front();
        checkOutput("out_sh", out_sh, got.sh);
        checkOutput("out_last", W'(out_last), W'(got.last));
        if (got.kn) checkOutput("plain", W'(unmask(out_sh)), W'(got.plain));
      end
    end
    if (in_valid && in_ready) begin
      ex.sh    = pack_sh(e);
      ex.last  = ((beat_n % BPS) == BPS - 1);
      ex.kn    = kn;
      ex.plain = known;
      sb.push_back(ex);
      beat_n++;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] v_db;
    logic [31:0] v_8e;
    logic [31:0] v_f2;
    logic [31:0] v_9f;
    v_db = col4(8'hdb, 8'h13, 8'h53, 8'h45);
    v_8e = col4(8'h8e, 8'h4d, 8'ha1, 8'hbc);
    v_f2 = col4(8'hf2, 8'h0a, 8'h22, 8'h5c);
    v_9f = col4(8'h9f, 8'hdc, 8'h58, 8'h9d);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sh     = '0;
    in_bypass = 1'b0;
`ifdef MSK_INVMC_EN
    in_inv    = 1'b0;
`endif
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", W'(out_valid), W'(1'b0));
    checkOutput("rst_out_last", W'(out_last), W'(1'b0));
    checkOutput("rst_out_sh", out_sh, '0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("in_ready_after_rst", W'(in_ready), W'(1'b1));

    // Latency on an empty pipe, then seven more beats back to back
    applyStimulus(1'b1, v_db, 1'b0, 1'b0, 1'b1, 1'b1, v_8e);
    for (int i = 1; i < PIPE; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("lat_early", W'(obs_valid), W'(1'b0));
    end
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("lat_due", W'(obs_valid), W'(1'b1));
    for (int i = PIPE + 1; i < 8; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(PIPE + 2);

    applyStimulus(1'b1, v_f2, 1'b0, 1'b0, 1'b1, 1'b1, v_9f);
`ifdef MSK_INVMC_EN
    applyStimulus(1'b1, v_8e, 1'b0, 1'b1, 1'b1, 1'b1, v_db);
    applyStimulus(1'b1, v_9f, 1'b0, 1'b1, 1'b1, 1'b1, v_f2);
`endif
    applyStimulus(1'b1, col4(8'h01, 8'h02, 8'h03, 8'h04), 1'b1, 1'b1, 1'b1, 1'b1,
                  col4(8'h01, 8'h02, 8'h03, 8'h04));
    idle(PIPE + 2);

    // Fill the pipe under backpressure and hold it for five cycles
    for (int i = 0; i < PIPE; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_in_ready", W'(obs_ready), W'(1'b0));
      checkOutput("stall_out_valid", W'(obs_valid), W'(1'b1));
      checkOutput("stall_out_sh", obs_sh, sb[0].sh);
    end
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("full_accept_drain", W'(obs_ready), W'(1'b1));
    idle(PIPE + 3);
    checkOutput("stall_drained", W'(sb.size()), '0);

    for (int i = 0; i < 1000; i++) applyStimulus(1'b1, v_db, 1'b0, 1'b0, 1'b1, 1'b1, v_8e);
    idle(PIPE + 2);

    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 4) == 0, 1'($urandom % 2),
                    ($urandom % 4) != 0, 1'b0, 32'h0);
    idle(PIPE + 3);
    checkOutput("random_drained", W'(sb.size()), '0);

    // Reset with two beats in flight and the beat counter at 2
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    beat_n = 0;
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", W'(out_valid), W'(1'b0));
    checkOutput("midrst_out_sh", out_sh, '0);
    sb.delete();
    beat_n = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(PIPE + 2);
    checkOutput("post_rst_drained", W'(sb.size()), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
